// File: rtl/ram_bist_pkg.sv
// Shared types, default geometry and the test-pattern function for the ram_bist
// self-test initiator.
package ram_bist_pkg;

  localparam int          DEF_ADDR_W = 5;
  localparam int          DEF_DATA_W = 4;
  localparam logic [3:0]  DEF_SEED   = 4'hA;
  // Patterns are computed at this width and truncated by the caller to DATA_W.
  localparam int          PAT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                               input logic [PAT_W-1:0] seed,
                                               input logic             inv);
    return (addr ^ seed) ^ {PAT_W{inv}};
  endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read-back comparator for ram_bist: delays the issued address/expected data by one
// cycle to line up with registered RAM read data, counts mismatches, records the first.
module ram_bist_checker
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [ADDR_W+1:0] err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W+1:0] err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              seen_q, seen_d;
  logic              mism;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      addr_q  <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    vld_d   = issue_i;
    addr_d  = addr_i;
    exp_d   = exp_i;
    err_d   = err_q;
    first_d = first_q;
    seen_d  = seen_q;
    // Case inequality so that X/Z read data is flagged rather than silently passing.
    mism    = vld_q && (rdata_i !== exp_q);
    if (clear_i) begin
      err_d   = '0;
      first_d = '0;
      seen_d  = 1'b0;
    end else if (mism) begin
      if (err_q != '1) err_d = err_q + (ADDR_W+2)'(1);
      if (!seen_q) begin
        first_d = addr_q;
        seen_d  = 1'b1;
      end
    end
  end

  assign err_cnt_o        = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: rtl/ram_bist.sv
// March-style write-all/read-all BIST initiator for a small synchronous RAM.
// Define RAM_BIST_INV_PASS_EN to add a second pass with the inverted pattern.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W = DEF_ADDR_W,
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              inv_q, inv_d;
  logic              clear;
  logic [PAT_W-1:0]  pat_full;
  logic [DATA_W-1:0] pat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          inv_d   = 1'b0;
          clear   = 1'b1;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) state_d = ST_READ;
      end
      ST_READ: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        cnt_d = '0;
`ifdef RAM_BIST_INV_PASS_EN
        if (!inv_q) begin
          state_d = ST_WRITE;
          inv_d   = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
`else
        state_d = ST_DONE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pat_full = pattern(PAT_W'(cnt_q), PAT_W'(SEED), inv_q);
  assign pat      = pat_full[DATA_W-1:0];

  // RAM pins decode straight from state so an asynchronous reset drops mem_we at once.
  assign busy      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = ((state_q == ST_WRITE) || (state_q == ST_READ)) ? cnt_q : '0;
  assign mem_wdata = (state_q == ST_WRITE) ? pat : '0;
  assign pass      = done && (err_cnt == '0);

  ram_bist_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_checker (
    .clk              (clk),
    .rst              (rst),
    .clear_i          (clear),
    .issue_i          (state_q == ST_READ),
    .addr_i           (cnt_q),
    .exp_i            (pat),
    .rdata_i          (mem_rdata),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err_addr)
  );

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist with a behavioural 32x4 RAM and injectable read faults.
module tb_ram_bist;

  localparam int         AW    = 5;
  localparam int         DW    = 4;
  localparam int         DEPTH = 32;
  localparam logic [3:0] SEED  = 4'hA;
`ifdef RAM_BIST_INV_PASS_EN
  localparam int         NPASS = 2;
`else
  localparam int         NPASS = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic          busy, done, pass, mem_we;
  logic [AW+1:0] err_cnt;
  logic [AW-1:0] first_err_addr, mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  ram_bist dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // RAM model with read-side fault injection
  int            fault_mode = 0;   // 0 none, 1 bit3 stuck-at-0, 2 one address returns fault_val
  logic [AW-1:0] fault_addr = '0;
  logic [DW-1:0] fault_val  = '0;
  logic [DW-1:0] ram [DEPTH];

  function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] s);
    case (fault_mode)
      1:       return s & 4'h7;
      2:       return (a == fault_addr) ? fault_val : s;
      default: return s;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else        mem_rdata     <= faulty(mem_addr, ram[mem_addr]);
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_pat(input int a, input int p);
    logic [DW-1:0] v;
    v = 4'(a) ^ SEED;
    if (p != 0) v = ~v;
    return v;
  endfunction

  // driver: one full test run, checked against the model's predicted result
  task automatic run_test(input string tag, input bit glitch);
    int            n, exp_errs, exp_first;
    bit            found;
    logic [DW-1:0] e, g;
    logic [31:0]   exp_q[$];
    exp_errs = 0; exp_first = 0; found = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        e = model_pat(a, p);
        g = faulty(5'(a), e);
        if (g !== e) begin
          exp_errs++;
          if (!found) begin
            exp_first = a;
            found = 1;
          end
        end
      end
    end
    exp_q.push_back(32'((2*DEPTH+1)*NPASS));
    exp_q.push_back(32'(exp_errs));
    exp_q.push_back(32'(exp_first));

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      start = glitch && (n == 10 || n == 40);
      @(negedge clk);
    end
    start = 1'b0;
    check_eq({tag, ":busy_cycles"}, 32'(n), exp_q.pop_front());
    check_eq({tag, ":done"},        32'(done), 32'd1);
    check_eq({tag, ":pass"},        32'(pass), 32'(exp_errs == 0));
    check_eq({tag, ":err_cnt"},     32'(err_cnt), exp_q.pop_front());
    check_eq({tag, ":first_err"},   32'(first_err_addr), exp_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ":busy"},      32'(busy), 32'd0);
    check_eq({tag, ":done"},      32'(done), 32'd0);
    check_eq({tag, ":pass"},      32'(pass), 32'd0);
    check_eq({tag, ":err_cnt"},   32'(err_cnt), 32'd0);
    check_eq({tag, ":first_err"}, 32'(first_err_addr), 32'd0);
    check_eq({tag, ":mem_we"},    32'(mem_we), 32'd0);
    check_eq({tag, ":mem_addr"},  32'(mem_addr), 32'd0);
    check_eq({tag, ":mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    fault_mode = 0;
    run_test("clean", 1'b0);
    check_eq("backdoor_ram3",  32'(ram[3]),  32'(model_pat(3, NPASS-1)));
    check_eq("backdoor_ram31", 32'(ram[31]), 32'(model_pat(31, NPASS-1)));

    fault_mode = 1;
    run_test("stuck3", 1'b0);
    // reset while DONE with errors recorded must wipe the results
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_done");
    @(negedge clk); rst = 1'b0;

    fault_mode = 2; fault_addr = 5'd12; fault_val = 4'h0;
    run_test("ram12", 1'b0);
    fault_mode = 0;
    run_test("restart", 1'b0);

    run_test("glitch", 1'b1);

    // asynchronous reset in the middle of WRITE
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    check_eq("midwrite:mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_write");
    @(negedge clk); rst = 1'b0;
    run_test("after_rst", 1'b0);

    for (int r = 0; r < 4; r++) begin
      fault_mode = 2;
      fault_addr = 5'($urandom_range(0, DEPTH-1));
      fault_val  = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_test("rand", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Built-in self-test initiator for the 32x4 synchronous RAM block; drives the RAM's write-enable, address and write-data pins and checks its registered read data.
- On a start pulse, writes a deterministic pattern to every address, reads every address back, and reports a pass/fail result.
- Sits beside the RAM; a mux in the parent selects between normal traffic and this block while busy=1.

Parameters:
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W words.
- DATA_W, 4, RAM data width; must be <= ADDR_W.
- SEED, 4'hA, DATA_W-bit XOR seed; pattern(a) = a[DATA_W-1:0] ^ SEED.

Ports:
- clk  input  1  single clock; everything on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a test; sampled only in IDLE or DONE.
- busy  output  1  high from the first write cycle through the final check cycle.
- done  output  1  high in DONE; held until the next accepted start or reset.
- pass  output  1  valid while done=1; 1 when err_cnt==0.
- err_cnt  output  ADDR_W+2  number of mismatching reads; saturates at all-ones.
- first_err_addr  output  ADDR_W  address of the first mismatch; 0 if none.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM registered read data.

Behaviour:
- Reset values: busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, mem_we=0, mem_addr=0, mem_wdata=0; state=IDLE; address counter=0.
- RAM timing contract: if mem_addr=A with mem_we=0 during cycle k, mem_rdata holds ram[A] during cycle k+1. The checker compares one cycle behind the address it issues, using a registered copy of the issued address.
- States:
  - IDLE: start=1 -> WRITE. Clears err_cnt, first_err_addr, the first-error flag and the counter.
  - WRITE: mem_we=1, mem_addr=cnt, mem_wdata=pattern(cnt). cnt increments each cycle. When cnt==DEPTH-1, go to READ and wrap cnt to 0.
  - READ: mem_we=0, mem_addr=cnt. From the second READ cycle onward, compare mem_rdata against pattern(previous addr). When cnt==DEPTH-1, go to DRAIN.
  - DRAIN: one cycle; mem_we=0, mem_addr=0; compares the last address (DEPTH-1) -> DONE.
  - DONE: done=1, pass=(err_cnt==0). start=1 -> WRITE, with the same clears as IDLE.
- Cycle count: busy is high for exactly 2*DEPTH+1 cycles (65 at defaults). done rises in the cycle after DRAIN.
- Mismatch handling:
  - Any bit inequality counts as a mismatch; X/Z on mem_rdata counts as a mismatch in simulation.
  - Each mismatch increments err_cnt, saturating.
  - first_err_addr latches only on the first mismatch of a run.
- Outside WRITE, mem_wdata=0; mem_we is 0 in IDLE, READ, DRAIN and DONE.
- start while busy is ignored, with no effect on state or counters. start held high for several cycles in IDLE is accepted once; it restarts only if still high in DONE.
- rst mid-run forces IDLE immediately (asynchronous). mem_we drops without waiting for the clock edge and all results clear.

Optional Feature:
- RAM_BIST_INV_PASS_EN defined: after the first DRAIN, a second WRITE/READ/DRAIN pass runs with pattern(a) inverted. busy lasts 2*(2*DEPTH+1) cycles (130 at defaults). err_cnt and first_err_addr accumulate across both passes. States gain a pass bit; the second pass does not reset the error registers.
- Undefined: single pass only, exactly as above.

Decomposition:
- Package ram_bist_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - default ADDR_W/DATA_W/SEED constants;
  - pure function pattern(addr, seed, inv).
- Sub-module ram_bist_checker holds the comparator, the delayed address/expected-data register, the saturating err_cnt and the first-error capture. The top level keeps the FSM and address counter.

Test Plan:
- Fault-free 32x4 RAM model, pulse start: busy high exactly 65 cycles; then done=1, pass=1, err_cnt=0, first_err_addr=0. Backdoor check shows ram[3]=4'h9 and ram[31]=4'h5.
- RAM model with data bit3 stuck-at-0 at every address: errors at addr 0-7 and 16-23; err_cnt=16, first_err_addr=0, pass=0.
- Single fault, ram[12] read returns 4'h0 (expected 4'h6): err_cnt=1, first_err_addr=12. A restart with the fault removed gives err_cnt=0, pass=1.
- start pulsed at busy cycle 10 and again at cycle 40: no restart, still 65 busy cycles. Assert rst at cycle 20 of WRITE: mem_we=0 immediately, all outputs return to reset values, and the next start runs normally.
- With RAM_BIST_INV_PASS_EN and a fault-free RAM: busy for 130 cycles, pass=1. The stuck-bit3 model gives err_cnt=32, first_err_addr=0.
